uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Serial front end of the image path: receives 8N1 UART bytes on rx (16x oversampled,
//   baud tick from an internal DVSR divider) and buffers them in a first-word-fall-through
//   FIFO. Downstream consumers (tiling/BRAM loader) read bytes with rd_uart.
//   Flags empty/full, framing error and overrun.
// PARAMETERS
//   DVSR    326  system clocks per oversample tick (50 MHz / (16*326) ~= 9600 baud)
//   DBIT    8    data bits per frame, LSB first
//   SB_TICK 16   oversample ticks spent in the stop bit (16 = 1 stop bit)
//   ADDR_W  4    FIFO address width; depth = 2**ADDR_W = 16 bytes
// PORTS
//   iClk        in   1     system clock, all logic on rising edge
//   iRst        in   1     asynchronous, active-low reset
//   rx          in   1     serial line, idle high, asynchronous to iClk
//   rd_uart     in   1     pop head byte of FIFO this cycle (ignored when oRxEmpty=1)
//   oData       out  DBIT  FIFO head byte (valid when oRxEmpty=0)
//   oRxEmpty    out  1     FIFO empty
//   oRxFull     out  1     FIFO full
//   oRxDoneTick out  1     1-cycle pulse: good frame received and written to FIFO
//   oFrameErr   out  1     1-cycle pulse: stop bit sampled low, byte discarded
//   oOverrun    out  1     sticky: good byte arrived while FIFO full (byte dropped)
// BEHAVIOUR
//   Reset (iRst=0, async): FSM=IDLE, tick counter=0, FIFO pointers=0, storage=0,
//     oData=8'h00, oRxEmpty=1, oRxFull=0, oRxDoneTick=0, oFrameErr=0, oOverrun=0.
//     Reset mid-frame aborts the frame; no partial byte is ever written.
//   rx passes a 2-FF synchronizer (reset value 1); all FSM decisions use synced rx.
//   Baud gen: counter 0..DVSR-1, free-running; s_tick=1 for one clock when count==DVSR-1.
//   FSM (s = tick count 0..15, n = bit index 0..DBIT-1):
//     IDLE : synced rx==0 -> START, s=0.
//     START: on s_tick, s==7 (mid start bit): rx==0 -> DATA, s=0, n=0; rx==1 -> IDLE
//            (glitch rejected, no flags). Else s++.
//     DATA : on s_tick, s==15: shift rx in at MSB (b <= {rx, b[DBIT-1:1]}), s=0;
//            n==DBIT-1 -> STOP (or PARITY when enabled) else n++. Else s++.
//     STOP : on s_tick, s==SB_TICK-1: rx==1 -> push b, oRxDoneTick=1 (or oOverrun
//            set if full, no done tick); rx==0 -> oFrameErr=1, discard. -> IDLE.
//   Pulse outputs are registered: asserted the cycle after the deciding s_tick.
//   FIFO: FWFT; oData = mem[rd_ptr]; write when push && !full; read when rd_uart && !empty.
//     Simultaneous push+pop when full: both occur, count unchanged, no overrun.
//     Simultaneous push+pop when empty: pop ignored, push occurs, oRxEmpty=0 next cycle.
//     Pointers wrap modulo 2**ADDR_W; full/empty from extra wrap bit comparison.
//   oOverrun clears only on reset.
//   Latency: rx stop-bit mid-point -> oData/oRxEmpty update = 1 clock after s_tick.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: frame is 8E1; FSM adds PARITY state between DATA and STOP,
//     sampled at s==15; bit must equal ^b (even). Mismatch -> byte discarded at STOP with
//     oFrameErr=1 (also if stop bit low). Parity error does not touch oOverrun.
//   Not defined: 8N1 only, no PARITY state, no parity logic synthesized.
// TESTING  (bit time = 16*326*20 ns = 104320 ns at 50 MHz)
//   Send 0x55 8N1 -> one oRxDoneTick pulse after stop, oData=0x55, oRxEmpty=0; rd_uart 1 clk -> oRxEmpty=1.
//   Send bytes 0x01..0x11 (17) without reads -> oRxFull=1 after 16th, oOverrun=1 after 17th; reads return 0x01..0x10 in order.
//   rx low 20000 ns then high (< 7 ticks) -> no done tick, no frame error, FSM back to IDLE.
//   Send 0xA3 with stop bit driven 0 -> oFrameErr pulse once, FIFO empty, next 0x3C received correctly.
//   Drop iRst during data bit 4 of 0xFF, release, send 0x81 -> FIFO holds only 0x81, all flags 0.
//   With UART_RX_PARITY_EN: 0x07 with parity 1 accepted; 0x07 with parity 0 -> oFrameErr, FIFO unchanged.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a first-word-fall-through byte FIFO.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with an even-parity check).
// Without the macro the receiver is plain 8N1 and no parity logic exists.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int DVSR    = 326,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int ADDR_W  = 4
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] oData,
    output logic            oRxEmpty,
    output logic            oRxFull,
    output logic            oRxDoneTick,
    output logic            oFrameErr,
    output logic            oOverrun
);
    localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CW-1:0] TICK_LAST = CW'(DVSR - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DBIT - 1);
    localparam logic [3:0]    SB_LAST   = 4'(SB_TICK - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    logic            r_rx_meta, r_rx_sync;
    logic [CW-1:0]   r_tick_cnt;
    logic            w_s_tick;
    state_t          r_state, state_next;
    logic [3:0]      r_s, s_next;
    logic [NW-1:0]   r_n, n_next;
    logic [DBIT-1:0] r_b, b_next;
`ifdef UART_RX_PARITY_EN
    logic            r_par_err, par_next;
`endif
    logic            w_push, w_ferr;
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic            w_empty, w_full, w_wr, w_rd, w_ovr;
    logic            r_done, r_ferr, r_overrun;
    logic [DBIT-1:0] w_mem [DEPTH];

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)                    r_tick_cnt <= '0;
        else if (r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
        else                          r_tick_cnt <= r_tick_cnt + CW'(1);
    end
    assign w_s_tick = (r_tick_cnt == TICK_LAST);

    // Receiver state register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_state <= state_next;
            r_s     <= s_next;
            r_n     <= n_next;
            r_b     <= b_next;
`ifdef UART_RX_PARITY_EN
            r_par_err <= par_next;
`endif
        end
    end

    // Receiver next-state logic: start-bit qualification, bit sampling at mid-bit, stop check.
    always_comb begin
        state_next = r_state;
        s_next     = r_s;
        n_next     = r_n;
        b_next     = r_b;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = r_par_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_sync) begin
                    state_next = ST_START;
                    s_next     = 4'd0;
                end
            end
            ST_START: begin
                if (w_s_tick) begin
                    if (r_s == 4'd7) begin
                        if (!r_rx_sync) begin
                            state_next = ST_DATA;
                            s_next     = 4'd0;
                            n_next     = '0;
`ifdef UART_RX_PARITY_EN
                            par_next   = 1'b0;
`endif
                        end else begin
                            state_next = ST_IDLE;   // short low pulse: not a start bit
                        end
                    end else begin
                        s_next = r_s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_s_tick) begin
                    if (r_s == 4'd15) begin
                        b_next = {r_rx_sync, r_b[DBIT-1:1]};
                        s_next = 4'd0;
                        if (r_n == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            n_next = r_n + NW'(1);
                        end
                    end else begin
                        s_next = r_s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_s_tick) begin
                    if (r_s == 4'd15) begin
                        par_next   = (r_rx_sync != (^r_b));
                        s_next     = 4'd0;
                        state_next = ST_STOP;
                    end else begin
                        s_next = r_s + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (w_s_tick) begin
                    if (r_s == SB_LAST) begin
`ifdef UART_RX_PARITY_EN
                        if (r_rx_sync && !r_par_err) w_push = 1'b1;
                        else                         w_ferr = 1'b1;
`else
                        if (r_rx_sync) w_push = 1'b1;
                        else           w_ferr = 1'b1;
`endif
                        state_next = ST_IDLE;
                    end else begin
                        s_next = r_s + 4'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FIFO control: a pop frees a slot in the same cycle, so push+pop while full both proceed.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_rd    = rd_uart && !w_empty;
    assign w_wr    = w_push && (!w_full || w_rd);
    assign w_ovr   = w_push && w_full && !w_rd;

    // FIFO pointers with an extra wrap bit.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Byte storage: one resettable register per entry so the head reads out combinationally.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic [DBIT-1:0] r_entry;
            // Capture the received byte when this entry is the write target.
            always_ff @(posedge iClk or negedge iRst) begin
                if (!iRst)
                    r_entry <= '0;
                else if (w_wr && (r_wr_ptr[ADDR_W-1:0] == ADDR_W'(gi)))
                    r_entry <= r_b;
            end
            assign w_mem[gi] = r_entry;
        end
    endgenerate

    // Registered status pulses and the sticky overrun flag.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_wr;
            r_ferr    <= w_ferr;
            r_overrun <= r_overrun | w_ovr;
        end
    end

    assign oData       = w_mem[r_rd_ptr[ADDR_W-1:0]];
    assign oRxEmpty    = w_empty;
    assign oRxFull     = w_full;
    assign oRxDoneTick = r_done;
    assign oFrameErr   = r_ferr;
    assign oOverrun    = r_overrun;

endmodule
